// File: rtl/painter_qsys_key_in.sv
// Avalon-MM key input port: synchronizes and debounces active-low keys and
// captures debounced presses (1->0) into a maskable, write-1-to-clear interrupt register.
module painter_qsys_key_in #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] clr;
    logic             wr_en;
    logic             unused_ok;

    // Only the low WIDTH bits of writedata reach any register.
    assign unused_ok = &{1'b0, writedata};

    assign wr_en = chipselect & ~write_n;

    // A bit follows sync2 only after CNT_MAX consecutive mismatching edges plus
    // the loading edge; any return to equality restarts the count.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        fall      = deb_q & ~deb_d;
        clr       = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        edgecap_d = (edgecap_q & ~clr) | fall;
        irqmask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            deb_q     <= '1;
            irqmask_q <= '0;
            edgecap_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= in_port;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = deb_q;
            2'd2:    readdata[WIDTH-1:0] = irqmask_q;
            2'd3:    readdata[WIDTH-1:0] = edgecap_q;
            default: readdata = '0;
        endcase
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_painter_qsys_key_in.sv
// Directed, table-driven bench for painter_qsys_key_in with WIDTH=4, DEBOUNCE_CYCLES=4.
// Each step drives inputs for one rising edge, then checks readdata/irq 1 ns after it.
module tb_painter_qsys_key_in;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        rst;
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  keys;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[$];

    painter_qsys_key_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic [1:0] addr, input logic wr,
                       input logic [31:0] wdata, input logic [3:0] keys,
                       input logic [31:0] exp_rd, input logic exp_irq);
        vec_t v;
        v.rst = rst; v.addr = addr; v.wr = wr; v.wdata = wdata;
        v.keys = keys; v.exp_rd = exp_rd; v.exp_irq = exp_irq;
        tbl.push_back(v);
    endtask

    task automatic step(input string name, input vec_t v);
        reset      = v.rst;
        address    = v.addr;
        chipselect = v.wr;
        write_n    = ~v.wr;
        writedata  = v.wdata;
        in_port    = v.keys;
        @(posedge clk);
        #1;
        n_checks++;
        if (readdata !== v.exp_rd) begin
            n_errors++;
            $display("FAIL %s readdata: got %h expected %h", name, readdata, v.exp_rd);
        end
        n_checks++;
        if (irq !== v.exp_irq) begin
            n_errors++;
            $display("FAIL %s irq: got %b expected %b", name, irq, v.exp_irq);
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic hstep(input string name, input logic rst, input logic [1:0] addr,
                         input logic wr, input logic [31:0] wdata, input logic [3:0] keys,
                         input logic [31:0] exp_rd, input logic exp_irq);
        vec_t v;
        v.rst = rst; v.addr = addr; v.wr = wr; v.wdata = wdata;
        v.keys = keys; v.exp_rd = exp_rd; v.exp_irq = exp_irq;
        step(name, v);
    endtask

    initial begin
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = 4'hF;

        // Reset state, reset beating a write, ignored writes to 0 and 1.
        add(1, 0, 0, 0,            4'hF, 32'hF, 0);
        add(1, 2, 1, 32'hF,        4'hF, 32'h0, 0);
        add(0, 2, 0, 0,            4'hF, 32'h0, 0);
        add(0, 3, 0, 0,            4'hF, 32'h0, 0);
        add(0, 1, 0, 0,            4'hF, 32'h0, 0);
        add(0, 0, 1, 32'h0,        4'hF, 32'hF, 0);
        add(0, 1, 1, 32'hFFFFFFFF, 4'hF, 32'h0, 0);
        // Key0 press: deb[0] and edgecapture[0] change on the 6th edge.
        add(0, 0, 0, 0, 4'hE, 32'hF, 0);
        add(0, 0, 0, 0, 4'hE, 32'hF, 0);
        add(0, 0, 0, 0, 4'hE, 32'hF, 0);
        add(0, 0, 0, 0, 4'hE, 32'hF, 0);
        add(0, 3, 0, 0, 4'hE, 32'h0, 0);
        add(0, 3, 0, 0, 4'hE, 32'h1, 0);
        add(0, 0, 0, 0, 4'hE, 32'hE, 0);
        // Clear capture, enable mask bit 0, release key0 (no capture on release).
        add(0, 3, 1, 32'h1, 4'hE, 32'h0, 0);
        add(0, 2, 1, 32'h1, 4'hE, 32'h1, 0);
        for (int i = 0; i < 6; i++) add(0, 3, 0, 0, 4'hF, 32'h0, 0);
        add(0, 0, 0, 0, 4'hF, 32'hF, 0);
        // Masked press raises irq; write-1-to-clear drops it.
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 4'hE, 32'hF, 0);
        add(0, 3, 0, 0,     4'hE, 32'h1, 1);
        add(0, 3, 1, 32'h1, 4'hE, 32'h0, 0);
        add(0, 2, 1, 32'h0, 4'hE, 32'h0, 0);
        // 3-cycle glitch on key1 must not change deb.
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 4'hC, 32'hE, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 4'hE, 32'hE, 0);
        // Two 3-cycle glitches separated by one equal cycle: counter must restart.
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 4'hC, 32'hE, 0);
        add(0, 0, 0, 0, 4'hE, 32'hE, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 4'hC, 32'hE, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 4'hE, 32'hE, 0);
        add(0, 3, 0, 0, 4'hE, 32'h0, 0);

        foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

        // Clearing edgecapture[2] on the very edge it is set: set wins.
        for (int i = 0; i < 5; i++) hstep($sformatf("setwin_wait%0d", i), 0, 3, 0, 0, 4'hA, 32'h0, 0);
        hstep("setwin_edge",   0, 3, 1, 32'h4, 4'hA, 32'h4, 0);
        hstep("setwin_mask",   0, 2, 1, 32'h4, 4'hA, 32'h4, 1);
        hstep("setwin_unmask", 0, 2, 1, 32'h0, 4'hA, 32'h0, 0);
        hstep("setwin_keep",   0, 3, 0, 0,     4'hA, 32'h4, 0);
        hstep("setwin_deb",    0, 0, 0, 0,     4'hA, 32'hA, 0);
        hstep("setwin_clear",  0, 3, 1, 32'h4, 4'hA, 32'h0, 0);

        // Reset two edges into a press: count aborted, full latency afterwards.
        hstep("rst_a",      1, 0, 0, 0,     4'hF, 32'hF, 0);
        hstep("rst_b",      0, 0, 0, 0,     4'hF, 32'hF, 0);
        hstep("rst_press1", 0, 0, 0, 0,     4'hE, 32'hF, 0);
        hstep("rst_press2", 0, 0, 0, 0,     4'hE, 32'hF, 0);
        hstep("rst_mid",    1, 2, 1, 32'hF, 4'hE, 32'h0, 0);
        hstep("rst_after1", 0, 3, 0, 0,     4'hE, 32'h0, 0);
        for (int i = 2; i <= 5; i++) hstep($sformatf("rst_after%0d", i), 0, 0, 0, 0, 4'hE, 32'hF, 0);
        hstep("rst_after6", 0, 0, 0, 0,     4'hE, 32'hE, 0);
        hstep("rst_after7", 0, 3, 0, 0,     4'hE, 32'h1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
